id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

ID/EX pipeline register and EX-side operand selection for the RV32IM pipeline. It registers decoded operands and control, consumes the four registered forwarding enables from the forwarding unit, and resolves forwarded operands. It also detects load-use hazards, inserting one bubble and stalling IF/ID. It holds EX while the multi-cycle mul/div unit is busy, latching the resolved operands for the duration.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 16, width of opaque control bundle passed ID→EX
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- ID_VALID, MEM_READ_ID, REG_WRITE_ID  in  1 each  ID instruction valid / is load / writes rd
- USES_RS1_ID, USES_RS2_ID  in  1 each  ID instruction reads rs1 / rs2
- RS1_ID, RS2_ID, RD_ID  in  5 each  ID register addresses
- RS1_DATA_ID, RS2_DATA_ID, IMM_ID, PC_ID  in  XLEN each  register-file data, immediate, PC
- CTRL_ID  in  CTRL_W  control bundle
- FWD_RS1_MEM, FWD_RS2_MEM, FWD_RS1_WB, FWD_RS2_WB  in  1 each  registered forwarding enables, valid during EX cycle
- ALU_RESULT_MEM, WB_DATA  in  XLEN each  forward sources
- REG_WRITE_MEM, REG_WRITE_WB  in  1 each  producer actually writes rd
- FLUSH  in  1  branch/jump mispredict, kill ID→EX transfer
- MULDIV_BUSY  in  1  EX mul/div not finished
- OPERAND_A_EX, OPERAND_B_EX  out  XLEN each  resolved rs1/rs2 values
- IMM_EX, PC_EX  out  XLEN each
- RS1_EX, RS2_EX, RD_EX  out  5 each
- CTRL_EX  out  CTRL_W
- VALID_EX, MEM_READ_EX, REG_WRITE_EX  out  1 each
- STALL_IF_ID  out  1  hold PC and IF/ID register

## Operation
- FSM states: RUN, BUBBLE, HOLD. Reset → RUN.
- Forward select per operand, priority MEM > WB > register file.
  - MEM path taken only if the FWD_*_MEM enable is set, REG_WRITE_MEM=1 and RSx_EX≠0. WB path likewise with REG_WRITE_WB.
  - x0 reads always give 0.
- Load-use detect (combinational, RUN only): VALID_EX & MEM_READ_EX & RD_EX≠0 & ID_VALID & ((USES_RS1_ID & RS1_ID==RD_EX) | (USES_RS2_ID & RS2_ID==RD_EX)).
- RUN:
  - On load-use: STALL_IF_ID=1. Next edge loads a bubble (VALID_EX=0, CTRL/MEM_READ/REG_WRITE=0, RD/RS1/RS2_EX=0), then → BUBBLE.
  - Otherwise the ID fields are captured and the state stays RUN.
- BUBBLE: the stalled ID instruction is captured; load result then arrives via the WB forward path. → RUN.
- RUN/BUBBLE with MULDIV_BUSY=1 and VALID_EX=1:
  - ID/EX register is not updated; STALL_IF_ID=1; state → HOLD.
  - The resolved OPERAND_A/B are latched into hold registers on that edge.
- HOLD: outputs driven from the hold registers; forwarding is ignored. Stays in HOLD while MULDIV_BUSY=1; on MULDIV_BUSY=0 the next edge captures ID and returns to RUN.
- FLUSH=1 in any state: next edge loads a bubble and returns to RUN. FLUSH outranks load-use and BUBBLE capture. FLUSH does not break HOLD: while MULDIV_BUSY=1, the bubble loads on the first edge with MULDIV_BUSY=0.
- STALL_IF_ID = load-use in RUN | HOLD | (MULDIV_BUSY & VALID_EX). It is never asserted in the same cycle as FLUSH for load-use.

## Timing
- ID→EX latency 1 cycle; operand resolution is combinational within EX.
- Load-use costs exactly 1 bubble cycle; mul/div costs (busy cycles).
- RESET at any edge, including mid-HOLD or BUBBLE, sets:
  - all registered outputs, operand hold registers and STALL_IF_ID to 0
  - state to RUN
- Bubble RD_EX=0 guarantees the forwarding unit's matches against it are suppressed by the x0 rule.

## Structure
- Shared pipeline package: state enum {RUN,BUBBLE,HOLD}, XLEN, CTRL_W, REG_ZERO=5'd0.
- Sub-module `operand_fwd_mux`: one-operand priority mux with x0/write-enable qualification, instantiated twice.

## Test plan
- add x5←1+2 then add x6←x5+x5: MEM forward gives OPERAND_A/B=3, no stall.
- lw x7 (mem=0x55) then addi x8←x7+1: STALL_IF_ID high 1 cycle, one VALID_EX=0 bubble, then OPERAND_A=0x55 via WB.
- Producer writes x0 with forward enables set: OPERAND_A=0.
- div busy 5 cycles while MEM/WB producers retire: OPERAND_A/B stable at latched values for all 5 cycles, STALL_IF_ID high throughout.
- FLUSH coincident with load-use: bubble loaded, STALL_IF_ID=0, state RUN.
- RESET asserted in HOLD: next cycle all outputs 0, state RUN, STALL_IF_ID=0.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared pipeline definitions for the ID/EX operand stage: widths, stage states
// and the ID->EX register layout.
package id_ex_operand_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 16;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode/forwarding logic and the ID/EX operand stage.
// master drives the ID and forwarding side, slave is the stage itself.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    logic              ID_VALID, MEM_READ_ID, REG_WRITE_ID;
    logic              USES_RS1_ID, USES_RS2_ID;
    logic [4:0]        RS1_ID, RS2_ID, RD_ID;
    logic [XLEN-1:0]   RS1_DATA_ID, RS2_DATA_ID, IMM_ID, PC_ID;
    logic [CTRL_W-1:0] CTRL_ID;
    logic              FWD_RS1_MEM, FWD_RS2_MEM, FWD_RS1_WB, FWD_RS2_WB;
    logic [XLEN-1:0]   ALU_RESULT_MEM, WB_DATA;
    logic              REG_WRITE_MEM, REG_WRITE_WB;
    logic              FLUSH;
    logic              MULDIV_BUSY;

    logic [XLEN-1:0]   OPERAND_A_EX, OPERAND_B_EX;
    logic [XLEN-1:0]   IMM_EX, PC_EX;
    logic [4:0]        RS1_EX, RS2_EX, RD_EX;
    logic [CTRL_W-1:0] CTRL_EX;
    logic              VALID_EX, MEM_READ_EX, REG_WRITE_EX;
    logic              STALL_IF_ID;

    modport master (
        output ID_VALID, MEM_READ_ID, REG_WRITE_ID, USES_RS1_ID, USES_RS2_ID,
               RS1_ID, RS2_ID, RD_ID, RS1_DATA_ID, RS2_DATA_ID, IMM_ID, PC_ID, CTRL_ID,
               FWD_RS1_MEM, FWD_RS2_MEM, FWD_RS1_WB, FWD_RS2_WB,
               ALU_RESULT_MEM, WB_DATA, REG_WRITE_MEM, REG_WRITE_WB, FLUSH, MULDIV_BUSY,
        input  OPERAND_A_EX, OPERAND_B_EX, IMM_EX, PC_EX, RS1_EX, RS2_EX, RD_EX,
               CTRL_EX, VALID_EX, MEM_READ_EX, REG_WRITE_EX, STALL_IF_ID
    );

    modport slave (
        input  ID_VALID, MEM_READ_ID, REG_WRITE_ID, USES_RS1_ID, USES_RS2_ID,
               RS1_ID, RS2_ID, RD_ID, RS1_DATA_ID, RS2_DATA_ID, IMM_ID, PC_ID, CTRL_ID,
               FWD_RS1_MEM, FWD_RS2_MEM, FWD_RS1_WB, FWD_RS2_WB,
               ALU_RESULT_MEM, WB_DATA, REG_WRITE_MEM, REG_WRITE_WB, FLUSH, MULDIV_BUSY,
        output OPERAND_A_EX, OPERAND_B_EX, IMM_EX, PC_EX, RS1_EX, RS2_EX, RD_EX,
               CTRL_EX, VALID_EX, MEM_READ_EX, REG_WRITE_EX, STALL_IF_ID
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One-operand forward select: MEM result over WB data over register file,
// each path qualified by its producer write enable; x0 always reads zero.
module operand_fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [4:0]      rs_addr_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            fwd_mem_i,
    input  logic            fwd_wb_i,
    input  logic            reg_write_mem_i,
    input  logic            reg_write_wb_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] operand_o
);

    always_comb begin
        if (rs_addr_i == REG_ZERO) begin
            operand_o = '0;
        end else if (fwd_mem_i && reg_write_mem_i) begin
            operand_o = mem_data_i;
        end else if (fwd_wb_i && reg_write_wb_i) begin
            operand_o = wb_data_i;
        end else begin
            operand_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding, load-use bubble insertion
// and operand hold while the multi-cycle mul/div unit is busy.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input logic                  CLK,
    input logic                  RESET,
    id_ex_operand_stage_if.slave bus
);

    state_e          state_q, state_d;
    id_ex_t          ex_q, ex_d, id_pkt;
    logic [XLEN-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            flush_pend_q, flush_pend_d;
    logic            load_use, muldiv_stall;

    operand_fwd_mux u_fwd_a (
        .rs_addr_i       (ex_q.rs1),
        .rf_data_i       (ex_q.rs1_data),
        .fwd_mem_i       (bus.FWD_RS1_MEM),
        .fwd_wb_i        (bus.FWD_RS1_WB),
        .reg_write_mem_i (bus.REG_WRITE_MEM),
        .reg_write_wb_i  (bus.REG_WRITE_WB),
        .mem_data_i      (bus.ALU_RESULT_MEM),
        .wb_data_i       (bus.WB_DATA),
        .operand_o       (fwd_a)
    );

    operand_fwd_mux u_fwd_b (
        .rs_addr_i       (ex_q.rs2),
        .rf_data_i       (ex_q.rs2_data),
        .fwd_mem_i       (bus.FWD_RS2_MEM),
        .fwd_wb_i        (bus.FWD_RS2_WB),
        .reg_write_mem_i (bus.REG_WRITE_MEM),
        .reg_write_wb_i  (bus.REG_WRITE_WB),
        .mem_data_i      (bus.ALU_RESULT_MEM),
        .wb_data_i       (bus.WB_DATA),
        .operand_o       (fwd_b)
    );

    assign id_pkt = '{
        valid:     bus.ID_VALID,
        mem_read:  bus.MEM_READ_ID,
        reg_write: bus.REG_WRITE_ID,
        rs1:       bus.RS1_ID,
        rs2:       bus.RS2_ID,
        rd:        bus.RD_ID,
        ctrl:      bus.CTRL_ID,
        imm:       bus.IMM_ID,
        pc:        bus.PC_ID,
        rs1_data:  bus.RS1_DATA_ID,
        rs2_data:  bus.RS2_DATA_ID
    };

    assign load_use = (state_q == RUN) && ex_q.valid && ex_q.mem_read &&
                      (ex_q.rd != REG_ZERO) && bus.ID_VALID &&
                      ((bus.USES_RS1_ID && (bus.RS1_ID == ex_q.rd)) ||
                       (bus.USES_RS2_ID && (bus.RS2_ID == ex_q.rd)));

    assign muldiv_stall = bus.MULDIV_BUSY && ex_q.valid;

    // A flush seen while mul/div is still busy is remembered and applied on release.
    always_comb begin
        state_d      = state_q;
        ex_d         = ex_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        flush_pend_d = flush_pend_q;
        if (state_q == HOLD) begin
            if (bus.MULDIV_BUSY) begin
                flush_pend_d = flush_pend_q || bus.FLUSH;
            end else begin
                ex_d         = (bus.FLUSH || flush_pend_q) ? '0 : id_pkt;
                state_d      = RUN;
                flush_pend_d = 1'b0;
            end
        end else if (muldiv_stall) begin
            hold_a_d     = fwd_a;
            hold_b_d     = fwd_b;
            state_d      = HOLD;
            flush_pend_d = bus.FLUSH;
        end else if (bus.FLUSH) begin
            ex_d    = '0;
            state_d = RUN;
        end else if (load_use) begin
            ex_d    = '0;
            state_d = BUBBLE;
        end else begin
            ex_d    = id_pkt;
            state_d = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= RUN;
            ex_q         <= '0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ex_q         <= ex_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.OPERAND_A_EX = (state_q == HOLD) ? hold_a_q : fwd_a;
    assign bus.OPERAND_B_EX = (state_q == HOLD) ? hold_b_q : fwd_b;
    assign bus.IMM_EX       = ex_q.imm;
    assign bus.PC_EX        = ex_q.pc;
    assign bus.RS1_EX       = ex_q.rs1;
    assign bus.RS2_EX       = ex_q.rs2;
    assign bus.RD_EX        = ex_q.rd;
    assign bus.CTRL_EX      = ex_q.ctrl;
    assign bus.VALID_EX     = ex_q.valid;
    assign bus.MEM_READ_EX  = ex_q.mem_read;
    assign bus.REG_WRITE_EX = ex_q.reg_write;

    // HOLD stalls only while busy: on the release edge IF/ID must advance with EX.
    assign bus.STALL_IF_ID = (load_use && !bus.FLUSH) ||
                             ((state_q == HOLD) && bus.MULDIV_BUSY) ||
                             muldiv_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed pipeline scenarios
// followed by random traffic, all compared against a behavioural EX-slot model.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid, mem_read, reg_write;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] ctrl;
        logic [31:0] imm, pc, d1, d2;
    } slot_t;

    slot_t       m_ex;
    bit          m_holding, m_bubbled, m_flush_pending;
    logic [31:0] m_ha, m_hb;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] resolve(logic [4:0] rs, logic [31:0] rf, logic fm, logic fw);
        if (rs == 5'd0) return 32'd0;
        if (fm && bus.REG_WRITE_MEM) return bus.ALU_RESULT_MEM;
        if (fw && bus.REG_WRITE_WB) return bus.WB_DATA;
        return rf;
    endfunction

    function automatic bit model_load_use();
        return !m_holding && !m_bubbled && m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0 &&
               bus.ID_VALID && ((bus.USES_RS1_ID && bus.RS1_ID == m_ex.rd) ||
                                (bus.USES_RS2_ID && bus.RS2_ID == m_ex.rd));
    endfunction

    function automatic slot_t id_now();
        slot_t s;
        s.valid = bus.ID_VALID; s.mem_read = bus.MEM_READ_ID; s.reg_write = bus.REG_WRITE_ID;
        s.rs1 = bus.RS1_ID; s.rs2 = bus.RS2_ID; s.rd = bus.RD_ID; s.ctrl = bus.CTRL_ID;
        s.imm = bus.IMM_ID; s.pc = bus.PC_ID; s.d1 = bus.RS1_DATA_ID; s.d2 = bus.RS2_DATA_ID;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ea, eb;
        bit          st;
        ea = m_holding ? m_ha : resolve(m_ex.rs1, m_ex.d1, bus.FWD_RS1_MEM, bus.FWD_RS1_WB);
        eb = m_holding ? m_hb : resolve(m_ex.rs2, m_ex.d2, bus.FWD_RS2_MEM, bus.FWD_RS2_WB);
        st = (model_load_use() && !bus.FLUSH) || (m_holding && bus.MULDIV_BUSY) ||
             (bus.MULDIV_BUSY && m_ex.valid);
        check("opA", bus.OPERAND_A_EX, ea);
        check("opB", bus.OPERAND_B_EX, eb);
        check("stall", 32'(bus.STALL_IF_ID), 32'(st));
        check("valid", 32'(bus.VALID_EX), 32'(m_ex.valid));
        check("mem_read", 32'(bus.MEM_READ_EX), 32'(m_ex.mem_read));
        check("reg_write", 32'(bus.REG_WRITE_EX), 32'(m_ex.reg_write));
        check("rd", 32'(bus.RD_EX), 32'(m_ex.rd));
        check("rs1", 32'(bus.RS1_EX), 32'(m_ex.rs1));
        check("rs2", 32'(bus.RS2_EX), 32'(m_ex.rs2));
        check("ctrl", 32'(bus.CTRL_EX), 32'(m_ex.ctrl));
        check("imm", bus.IMM_EX, m_ex.imm);
        check("pc", bus.PC_EX, m_ex.pc);
    endtask

    // Advance the EX-slot model by one clock using the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            m_ex = '0; m_ha = 0; m_hb = 0;
            m_holding = 0; m_bubbled = 0; m_flush_pending = 0;
        end else if (m_holding) begin
            if (bus.MULDIV_BUSY) begin
                m_flush_pending = m_flush_pending || bus.FLUSH;
            end else begin
                m_ex = (bus.FLUSH || m_flush_pending) ? slot_t'(0) : id_now();
                m_holding = 0; m_flush_pending = 0;
            end
        end else if (bus.MULDIV_BUSY && m_ex.valid) begin
            m_ha = resolve(m_ex.rs1, m_ex.d1, bus.FWD_RS1_MEM, bus.FWD_RS1_WB);
            m_hb = resolve(m_ex.rs2, m_ex.d2, bus.FWD_RS2_MEM, bus.FWD_RS2_WB);
            m_holding = 1; m_bubbled = 0; m_flush_pending = bus.FLUSH;
        end else if (bus.FLUSH) begin
            m_ex = '0; m_bubbled = 0;
        end else if (model_load_use()) begin
            m_ex = '0; m_bubbled = 1;
        end else begin
            m_ex = id_now(); m_bubbled = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic set_id(input bit v, mr, rw, u1, u2, input logic [4:0] rs1, rs2, rd,
                          input logic [31:0] d1, d2);
        bus.ID_VALID = v; bus.MEM_READ_ID = mr; bus.REG_WRITE_ID = rw;
        bus.USES_RS1_ID = u1; bus.USES_RS2_ID = u2;
        bus.RS1_ID = rs1; bus.RS2_ID = rs2; bus.RD_ID = rd;
        bus.RS1_DATA_ID = d1; bus.RS2_DATA_ID = d2;
        bus.IMM_ID = $urandom; bus.PC_ID = $urandom; bus.CTRL_ID = 16'($urandom);
    endtask

    task automatic no_fwd();
        bus.FWD_RS1_MEM = 0; bus.FWD_RS2_MEM = 0; bus.FWD_RS1_WB = 0; bus.FWD_RS2_WB = 0;
        bus.REG_WRITE_MEM = 0; bus.REG_WRITE_WB = 0;
        bus.ALU_RESULT_MEM = $urandom; bus.WB_DATA = $urandom;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        no_fwd();
        bus.FLUSH = 0; bus.MULDIV_BUSY = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        model_edge();
        @(posedge clk);
        #1;
        cycle();
        rst = 0;

        // add x5 <- x1+x2 (1+2), then add x6 <- x5+x5 via MEM forward
        set_id(1, 0, 1, 1, 1, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2);
        cycle();
        set_id(1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0);
        sample();
        check("add_rf_a", bus.OPERAND_A_EX, 32'd1);
        check("add_rf_b", bus.OPERAND_B_EX, 32'd2);
        advance();
        idle();
        bus.FWD_RS1_MEM = 1; bus.FWD_RS2_MEM = 1; bus.REG_WRITE_MEM = 1; bus.ALU_RESULT_MEM = 32'd3;
        sample();
        check("memfwd_a", bus.OPERAND_A_EX, 32'd3);
        check("memfwd_b", bus.OPERAND_B_EX, 32'd3);
        check("memfwd_stall", 32'(bus.STALL_IF_ID), 32'd0);
        advance();

        // lw x7 then addi x8 <- x7+1: one stall, one bubble, WB forward of 0x55
        idle();
        set_id(1, 1, 1, 1, 0, 5'd2, 5'd0, 5'd7, 32'h100, 32'd0);
        cycle();
        set_id(1, 0, 1, 1, 0, 5'd7, 5'd0, 5'd8, 32'd0, 32'd0);
        sample();
        check("lu_stall", 32'(bus.STALL_IF_ID), 32'd1);
        advance();
        sample();
        check("lu_bubble_valid", 32'(bus.VALID_EX), 32'd0);
        check("lu_bubble_rd", 32'(bus.RD_EX), 32'd0);
        check("lu_bubble_stall", 32'(bus.STALL_IF_ID), 32'd0);
        advance();
        set_id(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        bus.FWD_RS1_WB = 1; bus.REG_WRITE_WB = 1; bus.WB_DATA = 32'h55;
        sample();
        check("lu_wbfwd_a", bus.OPERAND_A_EX, 32'h55);
        check("lu_after_valid", 32'(bus.VALID_EX), 32'd1);
        check("lu_after_rd", 32'(bus.RD_EX), 32'd8);
        advance();

        // x0 source with every forward enable set still reads zero
        idle();
        set_id(1, 0, 1, 1, 1, 5'd0, 5'd0, 5'd9, 32'hDEAD, 32'hBEEF);
        cycle();
        set_id(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        bus.FWD_RS1_MEM = 1; bus.FWD_RS2_MEM = 1; bus.FWD_RS1_WB = 1; bus.FWD_RS2_WB = 1;
        bus.REG_WRITE_MEM = 1; bus.REG_WRITE_WB = 1;
        bus.ALU_RESULT_MEM = 32'h1234; bus.WB_DATA = 32'h5678;
        sample();
        check("x0_a", bus.OPERAND_A_EX, 32'd0);
        check("x0_b", bus.OPERAND_B_EX, 32'd0);
        advance();

        // div busy 5 cycles while forward sources keep changing
        idle();
        set_id(1, 0, 1, 1, 1, 5'd3, 5'd4, 5'd10, 32'd10, 32'd20);
        cycle();
        set_id(1, 0, 1, 1, 0, 5'd10, 5'd0, 5'd11, 32'd0, 32'd0);
        bus.MULDIV_BUSY = 1; bus.FWD_RS1_MEM = 1; bus.REG_WRITE_MEM = 1; bus.ALU_RESULT_MEM = 32'h111;
        sample();
        check("div_enter_a", bus.OPERAND_A_EX, 32'h111);
        check("div_enter_b", bus.OPERAND_B_EX, 32'd20);
        check("div_enter_stall", 32'(bus.STALL_IF_ID), 32'd1);
        advance();
        for (int i = 0; i < 4; i++) begin
            bus.FWD_RS1_MEM = 1'($urandom); bus.FWD_RS2_MEM = 1'($urandom);
            bus.FWD_RS1_WB = 1'($urandom); bus.FWD_RS2_WB = 1'($urandom);
            bus.REG_WRITE_MEM = 1; bus.REG_WRITE_WB = 1;
            bus.ALU_RESULT_MEM = $urandom; bus.WB_DATA = $urandom;
            sample();
            check("div_hold_a", bus.OPERAND_A_EX, 32'h111);
            check("div_hold_b", bus.OPERAND_B_EX, 32'd20);
            check("div_hold_stall", 32'(bus.STALL_IF_ID), 32'd1);
            check("div_hold_rd", 32'(bus.RD_EX), 32'd10);
            advance();
        end
        bus.MULDIV_BUSY = 0;
        no_fwd();
        cycle();
        sample();
        check("div_release_rd", 32'(bus.RD_EX), 32'd11);
        check("div_release_valid", 32'(bus.VALID_EX), 32'd1);
        advance();

        // FLUSH coincident with load-use: bubble, no stall, back to normal capture
        idle();
        set_id(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0);
        cycle();
        set_id(1, 0, 1, 1, 0, 5'd12, 5'd0, 5'd13, 32'd0, 32'd0);
        bus.FLUSH = 1;
        sample();
        check("flush_lu_stall", 32'(bus.STALL_IF_ID), 32'd0);
        advance();
        bus.FLUSH = 0;
        set_id(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0);
        sample();
        check("flush_bubble_valid", 32'(bus.VALID_EX), 32'd0);
        check("flush_bubble_rd", 32'(bus.RD_EX), 32'd0);
        advance();
        sample();
        check("flush_next_rd", 32'(bus.RD_EX), 32'd14);
        advance();

        // RESET while holding for mul/div
        idle();
        set_id(1, 0, 1, 1, 1, 5'd3, 5'd4, 5'd15, 32'd7, 32'd8);
        cycle();
        set_id(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        bus.MULDIV_BUSY = 1;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        sample();
        check("rst_hold_a", bus.OPERAND_A_EX, 32'd0);
        check("rst_hold_b", bus.OPERAND_B_EX, 32'd0);
        check("rst_hold_valid", 32'(bus.VALID_EX), 32'd0);
        check("rst_hold_stall", 32'(bus.STALL_IF_ID), 32'd0);
        check("rst_hold_imm", bus.IMM_EX, 32'd0);
        advance();

        // random traffic over a small register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
                   1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom, $urandom);
            bus.FWD_RS1_MEM = 1'($urandom); bus.FWD_RS2_MEM = 1'($urandom);
            bus.FWD_RS1_WB = 1'($urandom); bus.FWD_RS2_WB = 1'($urandom);
            bus.REG_WRITE_MEM = 1'($urandom); bus.REG_WRITE_WB = 1'($urandom);
            bus.ALU_RESULT_MEM = $urandom; bus.WB_DATA = $urandom;
            bus.FLUSH = ($urandom_range(0, 9) == 0);
            bus.MULDIV_BUSY = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
